// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame decoder: FSM encoding, error causes
// and the payload length limit.
package uart_frame_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_HUNT    = 3'd0;
   localparam state_t ST_LEN     = 3'd1;
   localparam state_t ST_PAYLOAD = 3'd2;
   localparam state_t ST_CHK     = 3'd3;
   localparam state_t ST_HOLD    = 3'd4;

   localparam logic [1:0] ERR_LEN     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_CHK     = 2'd2;

   localparam int MAX_LEN = 8;

endpackage

// File: rtl/uart_frame_decoder_fetch.sv
// Request/acknowledge handshake with the UART receive buffer; one byte per
// request, captured by the consumer on the cycle 'got' is high.
module uart_byte_fetch (
   input  logic       CLK,
   input  logic       RST,
   input  logic       want,
   input  logic       byte_avail,
   input  logic       byte_ack,
   input  logic [7:0] byte_data,
   output logic       byte_rd,
   output logic       got,
   output logic [7:0] rx_byte
);

   assign got     = byte_rd & byte_ack;
   assign rx_byte = byte_data;

   // A new request waits for ack to return low so one ack never covers two bytes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         byte_rd <= 1'b0;
      end else if (got) begin
         byte_rd <= 1'b0;
      end else if (!byte_rd && want && byte_avail && !byte_ack) begin
         byte_rd <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_decoder.sv
// Reassembles sync/length-prefixed UART frames into 64-bit words.
// Define UART_FRAME_CHKSUM_EN to require a trailing XOR checksum byte.
//
//   state      | meaning
//   ST_HUNT    | discard bytes until SYNC_BYTE
//   ST_LEN     | length byte, 1..8 accepted
//   ST_PAYLOAD | payload bytes, little-endian into frm_data
//   ST_CHK     | checksum byte (checksum build only)
//   ST_HOLD    | word presented, no fetching until accepted
module uart_frame_decoder
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        byte_avail,
   output logic        byte_rd,
   input  logic        byte_ack,
   input  logic [7:0]  byte_data,
   output logic        frm_valid,
   input  logic        frm_ready,
   output logic [63:0] frm_data,
   output logic [3:0]  frm_len,
   output logic        frm_err,
   output logic [1:0]  err_code
);

   localparam int           CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] T_LIMIT = CW'(TIMEOUT_CYCLES);

   state_t        state;
   logic [2:0]    idx;
   logic [CW-1:0] tcnt;
   logic          want;
   logic          got;
   logic [7:0]    rx_byte;
   logic          in_frame;
   logic          timeout;
`ifdef UART_FRAME_CHKSUM_EN
   logic [7:0]    chk;
`endif

   // Allowing the fetch on the accept cycle lets the next request start right after the handshake.
   assign want     = (state != ST_HOLD) || frm_ready;
   assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
   assign timeout  = in_frame && !got && (tcnt == T_LIMIT);

   uart_byte_fetch u_fetch (
      .CLK        (CLK),
      .RST        (RST),
      .want       (want),
      .byte_avail (byte_avail),
      .byte_ack   (byte_ack),
      .byte_data  (byte_data),
      .byte_rd    (byte_rd),
      .got        (got),
      .rx_byte    (rx_byte)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tcnt <= '0;
      end else if (got || !in_frame) begin
         tcnt <= '0;
      end else if (tcnt != T_LIMIT) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_HUNT;
         idx       <= 3'd0;
         frm_valid <= 1'b0;
         frm_data  <= 64'd0;
         frm_len   <= 4'd0;
         frm_err   <= 1'b0;
         err_code  <= ERR_LEN;
`ifdef UART_FRAME_CHKSUM_EN
         chk       <= 8'd0;
`endif
      end else begin
         frm_err <= 1'b0;
         if (timeout) begin
            frm_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_HUNT;
         end else begin
            case (state)
               ST_HUNT: begin
                  if (got && (rx_byte == SYNC_BYTE)) state <= ST_LEN;
               end
               ST_LEN: begin
                  if (got) begin
                     if ((rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN))) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_LEN;
                        state    <= ST_HUNT;
                     end else begin
                        frm_len  <= rx_byte[3:0];
                        frm_data <= 64'd0;
                        idx      <= 3'd0;
`ifdef UART_FRAME_CHKSUM_EN
                        chk      <= rx_byte;
`endif
                        state    <= ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (got) begin
                     frm_data[{idx, 3'b000} +: 8] <= rx_byte;
                     idx <= idx + 1'b1;
`ifdef UART_FRAME_CHKSUM_EN
                     chk <= chk ^ rx_byte;
                     if ({1'b0, idx} == frm_len - 4'd1) state <= ST_CHK;
`else
                     if ({1'b0, idx} == frm_len - 4'd1) begin
                        frm_valid <= 1'b1;
                        state     <= ST_HOLD;
                     end
`endif
                  end
               end
`ifdef UART_FRAME_CHKSUM_EN
               ST_CHK: begin
                  if (got) begin
                     if (rx_byte != chk) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_CHK;
                        state    <= ST_HUNT;
                     end else begin
                        frm_valid <= 1'b1;
                        state     <= ST_HOLD;
                     end
                  end
               end
`endif
               ST_HOLD: begin
                  if (frm_ready) begin
                     frm_valid <= 1'b0;
                     state     <= ST_HUNT;
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with a behavioural receive buffer;
// expectations follow the checksum build when UART_FRAME_CHKSUM_EN is defined.
module tb_uart_frame_decoder;

`ifdef UART_FRAME_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int TMO = 50;
   localparam int NV  = 12;

   logic        CLK;
   logic        RST;
   logic        byte_avail;
   logic        byte_rd;
   logic        byte_ack;
   logic [7:0]  byte_data;
   logic        frm_valid;
   logic        frm_ready;
   logic [63:0] frm_data;
   logic [3:0]  frm_len;
   logic        frm_err;
   logic [1:0]  err_code;

   uart_frame_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .byte_avail (byte_avail),
      .byte_rd    (byte_rd),
      .byte_ack   (byte_ack),
      .byte_data  (byte_data),
      .frm_valid  (frm_valid),
      .frm_ready  (frm_ready),
      .frm_data   (frm_data),
      .frm_len    (frm_len),
      .frm_err    (frm_err),
      .err_code   (err_code)
   );

   typedef struct {
      int          n;
      logic [95:0] b;
      logic [7:0]  chk;
      bit          add_chk;
      bit          is_err;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  code;
      int          lat;
   } vec_t;

   typedef struct {
      bit          is_err;
      logic [63:0] data;
      logic [3:0]  len;
      logic [1:0]  code;
      int          lat;
   } ev_t;

   int          checks = 0;
   int          errors = 0;
   int          cycle_count = 0;
   int          last_cap = 0;
   int          rd_viol = 0;
   int          hold_viol = 0;
   int          err_wide = 0;
   int          bp_viol = 0;
   logic [7:0]  rxq[$];
   ev_t         events[$];
   ev_t         mon_ev;
   vec_t        vecs[NV];
   vec_t        v;
   bit          ok;
   int          n0;
   logic        prev_rd, prev_valid, prev_ready, prev_err;
   logic [63:0] prev_data;
   logic [3:0]  prev_len;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle_count <= cycle_count + 1;

   // Receive-buffer model and output monitor share one block so their order is fixed.
   always @(negedge CLK) begin
      if (byte_rd && !prev_rd && (!byte_avail || byte_ack)) rd_viol++;
      if (frm_valid && byte_rd) hold_viol++;
      if (prev_valid && !prev_ready &&
          (!frm_valid || frm_data !== prev_data || frm_len !== prev_len)) hold_viol++;
      if (prev_valid && prev_ready && frm_valid) hold_viol++;
      if (frm_err && prev_err) err_wide++;
      if (frm_valid && !prev_valid) begin
         mon_ev.is_err = 1'b0; mon_ev.data = frm_data; mon_ev.len = frm_len;
         mon_ev.code = 2'd0; mon_ev.lat = cycle_count - last_cap;
         events.push_back(mon_ev);
      end
      if (frm_err) begin
         mon_ev.is_err = 1'b1; mon_ev.data = 64'd0; mon_ev.len = 4'd0;
         mon_ev.code = err_code; mon_ev.lat = cycle_count - last_cap;
         events.push_back(mon_ev);
      end
      prev_rd = byte_rd; prev_valid = frm_valid; prev_ready = frm_ready;
      prev_err = frm_err; prev_data = frm_data; prev_len = frm_len;
      if (byte_ack) begin
         byte_ack = 1'b0;
      end else if (byte_rd && rxq.size() > 0) begin
         byte_ack  = 1'b1;
         byte_data = rxq.pop_front();
         last_cap  = cycle_count + 1;
      end
      byte_avail = (rxq.size() > 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic wait_event(input int base, input string name, output bit found);
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         @(negedge CLK); #1;
         if (events.size() > base) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: got no event expected one within 1000 cycles", name);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK); #1;
         if (rxq.size() == 0 && !byte_ack && !byte_rd) break;
      end
      repeat (5) @(negedge CLK);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rxq.push_back(b);
   endtask

   function automatic vec_t mk(input int n, input logic [95:0] b, input logic [7:0] chk,
                               input bit add_chk, input bit is_err, input logic [63:0] data,
                               input logic [3:0] len, input logic [1:0] code, input int lat);
      vec_t r;
      r.n = n; r.b = b; r.chk = chk; r.add_chk = add_chk; r.is_err = is_err;
      r.data = data; r.len = len; r.code = code; r.lat = lat;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(5, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 8'h03, 1, 0, 64'h332211, 4'd3, 2'd0, 0);
      vecs[1]  = mk(12, {8'h00, 8'h7F, 8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                         8'h07, 8'h08}, 8'h00, 1, 0, 64'h0807060504030201, 4'd8, 2'd0, 0);
      vecs[2]  = mk(2, {8'hA5, 8'h09}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd0, 0);
      vecs[3]  = mk(3, {8'hA5, 8'h01, 8'h42}, 8'h43, 1, 0, 64'h42, 4'd1, 2'd0, 0);
      vecs[4]  = mk(2, {8'hA5, 8'h00}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd0, 0);
      vecs[5]  = mk(3, {8'hA5, 8'h02, 8'hAA}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd1, TMO + 1);
      vecs[6]  = mk(1, {8'hA5}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd1, TMO + 1);
      vecs[7]  = CHK_EN ? mk(4, {8'hA5, 8'h01, 8'h5A, 8'h00}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd2, 0)
                        : mk(4, {8'hA5, 8'h01, 8'h5A, 8'h00}, 8'h00, 0, 0, 64'h5A, 4'd1, 2'd0, 0);
      vecs[8]  = mk(3, {8'hA5, 8'h01, 8'hA5}, 8'hA4, 1, 0, 64'hA5, 4'd1, 2'd0, 0);
      vecs[9]  = mk(4, {8'hA5, 8'h02, 8'hA5, 8'hA5}, 8'h02, 1, 0, 64'hA5A5, 4'd2, 2'd0, 0);
      vecs[10] = mk(2, {8'hA5, 8'hFF}, 8'h00, 0, 1, 64'd0, 4'd0, 2'd0, 0);
      vecs[11] = mk(6, {8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'h26, 1, 0,
                    64'hEFBEADDE, 4'd4, 2'd0, 0);

      RST = 1'b1; byte_avail = 1'b0; byte_ack = 1'b0; byte_data = 8'd0; frm_ready = 1'b0;
      prev_rd = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_err = 1'b0;
      prev_data = 64'd0; prev_len = 4'd0;
      repeat (3) @(negedge CLK);
      #1;
      check("reset_byte_rd", byte_rd, 0);
      check("reset_frm_valid", frm_valid, 0);
      check("reset_frm_data", frm_data, 0);
      check("reset_frm_len", frm_len, 0);
      check("reset_frm_err", frm_err, 0);
      check("reset_err_code", err_code, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      frm_ready = 1'b1;

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         n0 = events.size();
         @(posedge CLK); #1;
         for (int j = 0; j < v.n; j++) push(v.b[8*(v.n-1-j) +: 8]);
         if (v.add_chk && CHK_EN) push(v.chk);
         wait_event(n0, $sformatf("v%0d_event", i), ok);
         if (ok) begin
            check($sformatf("v%0d_is_err", i), events[n0].is_err, v.is_err);
            if (v.is_err) begin
               check($sformatf("v%0d_err_code", i), events[n0].code, v.code);
            end else begin
               check($sformatf("v%0d_frm_data", i), events[n0].data, v.data);
               check($sformatf("v%0d_frm_len", i), events[n0].len, v.len);
            end
            check($sformatf("v%0d_latency", i), events[n0].lat, v.lat);
         end
         drain();
         check($sformatf("v%0d_event_count", i), events.size() - n0, 1);
      end

      // Back-pressure: two frames queued while the consumer stalls.
      @(posedge CLK); #1;
      frm_ready = 1'b0;
      n0 = events.size();
      push(8'hA5); push(8'h02); push(8'h12); push(8'h34);
      if (CHK_EN) push(8'h24);
      push(8'hA5); push(8'h01); push(8'h77);
      if (CHK_EN) push(8'h76);
      wait_event(n0, "bp_first_event", ok);
      check("bp_first_data", frm_data, 64'h3412);
      check("bp_first_len", frm_len, 4'd2);
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK); #1;
         if (!frm_valid || frm_data !== 64'h3412 || frm_len !== 4'd2 || byte_rd) bp_viol++;
      end
      check("bp_hold_stable", bp_viol, 0);
      check("bp_buffer_untouched", rxq.size(), CHK_EN ? 4 : 3);
      @(posedge CLK); #1;
      frm_ready = 1'b1;
      @(negedge CLK); #1;
      check("bp_valid_before_accept", frm_valid, 1);
      @(negedge CLK); #1;
      check("bp_valid_after_accept", frm_valid, 0);
      check("bp_rd_after_accept", byte_rd, 1);
      wait_event(n0 + 1, "bp_second_event", ok);
      if (ok) begin
         check("bp_second_data", events[n0 + 1].data, 64'h77);
         check("bp_second_len", events[n0 + 1].len, 4'd1);
      end
      drain();

      // Reset in the middle of a payload.
      @(posedge CLK); #1;
      push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
      drain();
      @(posedge CLK); #2;
      RST = 1'b1;
      #1;
      check("rst_mid_byte_rd", byte_rd, 0);
      check("rst_mid_frm_valid", frm_valid, 0);
      check("rst_mid_frm_data", frm_data, 0);
      check("rst_mid_frm_len", frm_len, 0);
      check("rst_mid_frm_err", frm_err, 0);
      check("rst_mid_err_code", err_code, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      n0 = events.size();
      push(8'hA5); push(8'h01); push(8'h99);
      if (CHK_EN) push(8'h98);
      wait_event(n0, "post_rst_event", ok);
      if (ok) begin
         check("post_rst_is_err", events[n0].is_err, 0);
         check("post_rst_data", events[n0].data, 64'h99);
         check("post_rst_len", events[n0].len, 4'd1);
      end
      drain();

      check("fetch_rule", rd_viol, 0);
      check("hold_protocol", hold_viol, 0);
      check("err_one_cycle", err_wide, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
